// File: rtl/pulse_seq_pkg.sv
// Shared types and defaults for the pulse sequencer controller and its shift-register core.
// The optional abort feature is enabled by defining PULSE_SEQ_ABORT_EN.
package pulse_seq_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_sr_core.sv
// NAND-feedback shift register: synchronous clear, parallel load, and shift with tap-mask feedback.
module pulse_sr_core
  import pulse_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             fb;

  // Unselected taps are forced to 1 so they never pull the NAND low.
  always_comb begin
    fb  = ~&(q_q | ~taps);
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = load_val;
    end else if (shift_en) begin
      q_d = {q_q[WIDTH-2:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Burst controller for the NAND-feedback pulse generator: captures seed/taps/length on start,
// shifts exactly len cycles, then strobes done. Define PULSE_SEQ_ABORT_EN to add the abort port.
module pulse_seq_ctrl
  import pulse_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] tap_mask,
  input  logic [CNT_W-1:0] len,
`ifdef PULSE_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic             pulse_out,
  output logic [WIDTH-1:0] q
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load;
  logic             shift_en;
  logic             abort_hit;

`ifdef PULSE_SEQ_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // busy/done are computed for the next state so they come straight out of flops.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    taps_d   = taps_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load   = 1'b1;
          taps_d = tap_mask;
          cnt_d  = len;
          if (len != '0) begin
            state_d = RUN;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          shift_en = 1'b1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            busy_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      taps_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      taps_q  <= taps_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Load and shift use the tap value being latched in the same edge only when loading,
  // so shifting always uses the captured taps.
  pulse_sr_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .clr     (rst),
    .load    (load),
    .load_val(seed),
    .shift_en(shift_en),
    .taps    (taps_q),
    .q       (q)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign pulse_out = q[WIDTH-1] & busy_q;

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Self-checking bench for pulse_seq_ctrl: directed scenarios plus randomized bursts
// compared against a transaction-level model of the shift sequence.
module tb_pulse_seq_ctrl;

  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  seed;
  logic [W-1:0]  tap_mask;
  logic [CW-1:0] len;
`ifdef PULSE_SEQ_ABORT_EN
  logic          abort;
`endif
  logic          busy;
  logic          done;
  logic          pulse_out;
  logic [W-1:0]  q;

  int            checks = 0;
  int            errors = 0;
  logic [31:0]   pulses;
  logic [W-1:0]  last_q;

  always #5 clk = ~clk;

  pulse_seq_ctrl #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seed     (seed),
    .tap_mask (tap_mask),
    .len      (len),
`ifdef PULSE_SEQ_ABORT_EN
    .abort    (abort),
`endif
    .busy     (busy),
    .done     (done),
    .pulse_out(pulse_out),
    .q        (q)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Feedback is 1 exactly when at least one selected tap bit is 0.
  function automatic logic [W-1:0] model_step(input logic [W-1:0] v, input logic [W-1:0] t);
    logic fb;
    fb = ((v & t) != t);
    return {v[W-2:0], fb};
  endfunction

  task automatic check_quiet(input string tag, input logic [W-1:0] expq);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pulse"}, 32'(pulse_out), 32'd0);
    chk({tag, "_q"}, 32'(q), 32'(expq));
  endtask

  // Called in an IDLE cycle; returns in the following IDLE cycle (len+2 cycles later,
  // or abort_at+2 when aborted). abort_at=0 means no abort.
  task automatic do_burst(input logic [W-1:0] s, input logic [W-1:0] t,
                          input logic [CW-1:0] l, input bit hold, input int abort_at);
    logic [W-1:0] e;
    seed     = s;
    tap_mask = t;
    len      = l;
    start    = 1'b1;
    e        = s;
    pulses   = '0;
    for (int k = 1; k <= int'(l); k++) begin
      tick;
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      chk("run_q", 32'(q), 32'(e));
      chk("run_pulse", 32'(pulse_out), 32'(e[W-1]));
      pulses = {pulses[30:0], pulse_out};
      if (!hold) start = 1'($urandom);
      seed     = W'($urandom);
      tap_mask = W'($urandom);
      len      = CW'($urandom);
`ifdef PULSE_SEQ_ABORT_EN
      if (k == abort_at) begin
        abort = 1'b1;
        break;
      end
`endif
      e = model_step(e, t);
    end
    tick;
`ifdef PULSE_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    chk("done_strobe", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_pulse", 32'(pulse_out), 32'd0);
    chk("done_q", 32'(q), 32'(e));
    if (!hold) start = 1'b0;
    tick;
    check_quiet("post", e);
    last_q = e;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    seed     = 4'hF;
    tap_mask = 4'hF;
    len      = 8'd5;
`ifdef PULSE_SEQ_ABORT_EN
    abort    = 1'b0;
`endif

    // Reset held two cycles with start asserted
    tick;
    check_quiet("rst1", 4'h0);
    tick;
    check_quiet("rst2", 4'h0);
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      check_quiet("rst_after", 4'h0);
    end

    // Nominal sequence
    do_burst(4'b0000, 4'b1101, 8'd6, 1'b0, 0);
    chk("nom_final_q", 32'(last_q), 32'hD);
    chk("nom_pulses", pulses, 32'b000011);
    tick;
    check_quiet("nom_idle", 4'hD);

    // Zero length: done next cycle, q takes the seed
    do_burst(4'b1010, 4'b0110, 8'd0, 1'b0, 0);
    chk("len0_q", 32'(q), 32'hA);

    // start held continuously, three back-to-back bursts of len 3
    do_burst(4'b0101, 4'b0011, 8'd3, 1'b1, 0);
    do_burst(4'b0101, 4'b0011, 8'd3, 1'b1, 0);
    do_burst(4'b0101, 4'b0011, 8'd3, 1'b0, 0);

    // Reset in RUN cycle 3 of a len-6 burst
    seed     = 4'b0000;
    tap_mask = 4'b1101;
    len      = 8'd6;
    start    = 1'b1;
    tick;
    start = 1'b0;
    chk("kill_run1", 32'(busy), 32'd1);
    tick;
    tick;
    chk("kill_run3_q", 32'(q), 32'h3);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_quiet("kill_idle", 4'h0);
    for (int i = 0; i < 10; i++) begin
      tick;
      check_quiet("kill_after", 4'h0);
    end

`ifdef PULSE_SEQ_ABORT_EN
    do_burst(4'b0000, 4'b1101, 8'd6, 1'b0, 2);
    chk("abort2_q", 32'(last_q), 32'h1);
    do_burst(4'b0000, 4'b1101, 8'd6, 1'b0, 6);
    chk("abort_last_q", 32'(last_q), 32'hE);
`endif

    // Randomized bursts with idle gaps
    for (int i = 0; i < 25; i++) begin
      do_burst(W'($urandom), W'($urandom), CW'($urandom_range(0, 10)), 1'b0, 0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        tick;
        check_quiet("gap", last_q);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_seq_ctrl.md
# pulse_seq_ctrl

Controller that sequences a programmable shift-register pulse generator: latches a seed pattern, a feedback tap mask and a burst length on a start request, then clocks the NAND-feedback shift register for exactly that many cycles and reports completion. It sits between the register/config logic and the pulse output pin. It owns the generator core and guarantees no shifting outside an accepted burst.

## Interface
- WIDTH, 4, shift-register length in bits (≥2)
- CNT_W, 8, burst-length counter width
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- start  input  1  burst request; sampled only in IDLE
- seed  input  WIDTH  initial register contents, captured on accepted start
- tap_mask  input  WIDTH  feedback taps, captured on accepted start
- len  input  CNT_W  number of shift cycles, captured on accepted start
- abort  input  1  (only with PULSE_SEQ_ABORT_EN) terminate burst
- busy  output  1  high in RUN
- done  output  1  one-cycle completion strobe
- pulse_out  output  1  q[WIDTH-1] gated by busy
- q  output  WIDTH  current register contents

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1, len≠0 → q←seed, cnt←len, taps←tap_mask, → RUN. start=1, len=0 → → DONE, q←seed, no shift. start=0 → hold.
- RUN: every cycle fb = ~&(q | ~taps); q←{q[WIDTH-2:0], fb}; cnt←cnt−1. cnt=1 at the edge → last shift, → DONE.
- DONE: done=1 for one cycle, → IDLE. q holds its final value.
- Unselected taps count as 1. taps=0 gives fb=0, so zeros shift in.
- start in RUN or DONE is ignored, not queued. seed, tap_mask and len are ignored outside the capture edge.
- rst at any cycle, including mid-burst: state=IDLE, q=0, cnt=0, taps=0. Next cycle busy=0, done=0, pulse_out=0. No done strobe for the killed burst.

## Timing
- start high in cycle t → busy high in cycles t+1 … t+len. done high in cycle t+len+1. Next start is accepted in cycle t+len+2.
- len=0: done high in cycle t+1. busy never rises.
- pulse_out in RUN cycle k (1-based) equals bit WIDTH-1 of the register after k−1 shifts. It is 0 outside RUN.
- All outputs are registered or decoded from registered state. No combinational path from inputs to outputs.

## Configuration
- PULSE_SEQ_ABORT_EN defined:
  - abort port exists.
  - abort=1 in RUN → → DONE at that edge without shifting. done strobes next cycle. q holds.
  - abort in IDLE or DONE is ignored.
  - abort and the last shift in the same cycle: abort wins, so the last shift is skipped.
- Not defined: no abort port. A burst always runs to len.

## Structure
- Shared package pulse_seq_pkg: state enum (IDLE, RUN, DONE), default WIDTH and CNT_W constants.
- One sub-module, pulse_sr_core:
  - WIDTH-bit register with synchronous clear, load, shift-enable and tap-mask feedback.
  - Built from the team's existing d_ff cells or behavioral flops.
- The controller holds the FSM, the counter and the tap latch.

## Test plan
- Reset: assert rst 2 cycles with start=1 → busy=done=pulse_out=0, q=0000 throughout, and no burst afterwards until start is reasserted.
- Nominal, WIDTH=4: seed=0000, tap_mask=1101, len=6.
  - q after each shift: 0001, 0011, 0111, 1111, 1110, 1101.
  - pulse_out over the 6 RUN cycles: 0,0,0,0,1,1.
  - busy high 6 cycles, then done one cycle; q stays 1101 in DONE and IDLE.
- len=0 with seed=1010 → done in cycle t+1, busy never high, q=1010.
- start held high continuously, len=3 → bursts start in t, t+5, t+10. Each has busy 3 cycles and done 1 cycle, and start is ignored during RUN and DONE.
- rst asserted in RUN cycle 3 of a len=6 burst → next cycle IDLE, q=0000, and no done strobe at any later cycle.
- With PULSE_SEQ_ABORT_EN: abort in RUN cycle 2 of a len=6 burst → done in the following cycle, q=0001. Also abort coincident with the final shift → last shift skipped.
